// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - memop encodings, size codes, FSM states and decode helpers for dmem_ctrl
package dmem_ctrl_pkg;

    localparam int MMOP_W = 4;

    localparam logic [MMOP_W-1:0] MOP_NOP = 4'd0;
    localparam logic [MMOP_W-1:0] MOP_LB  = 4'd1;
    localparam logic [MMOP_W-1:0] MOP_LBU = 4'd2;
    localparam logic [MMOP_W-1:0] MOP_LH  = 4'd3;
    localparam logic [MMOP_W-1:0] MOP_LHU = 4'd4;
    localparam logic [MMOP_W-1:0] MOP_LW  = 4'd5;
    localparam logic [MMOP_W-1:0] MOP_SB  = 4'd6;
    localparam logic [MMOP_W-1:0] MOP_SH  = 4'd7;
    localparam logic [MMOP_W-1:0] MOP_SW  = 4'd8;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE,
        ST_DISCARD
    } state_e;

    function automatic logic is_load(input logic [MMOP_W-1:0] op);
        return (op == MOP_LB) || (op == MOP_LBU) || (op == MOP_LH) ||
               (op == MOP_LHU) || (op == MOP_LW);
    endfunction

    function automatic logic is_store(input logic [MMOP_W-1:0] op);
        return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
    endfunction

    // Unknown encodings size as byte so an idle/reset controller drives size 0.
    function automatic logic [1:0] op_size(input logic [MMOP_W-1:0] op);
        logic [1:0] s;
        case (op)
            MOP_LH, MOP_LHU, MOP_SH: s = SIZE_HALF;
            MOP_LW, MOP_SW:          s = SIZE_WORD;
            default:                 s = SIZE_BYTE;
        endcase
        return s;
    endfunction

    function automatic logic misaligned(input logic [MMOP_W-1:0] op, input logic [1:0] lo);
        logic [1:0] s;
        s = op_size(op);
        return ((s == SIZE_HALF) && lo[0]) || ((s == SIZE_WORD) && (lo != 2'b00));
    endfunction

    // Clears the address bits below the access size; identity for aligned accesses.
    function automatic logic [31:0] align_addr(input logic [MMOP_W-1:0] op, input logic [31:0] a);
        logic [31:0] r;
        case (op_size(op))
            SIZE_HALF: r = {a[31:1], 1'b0};
            SIZE_WORD: r = {a[31:2], 2'b00};
            default:   r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - store byte-lane/strobe replication and load lane extraction with extension
module dmem_lane
    import dmem_ctrl_pkg::*;
(
    input  logic [MMOP_W-1:0] memop,
    input  logic [1:0]        byte_off,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rdata,
    output logic [3:0]        wstrb,
    output logic [31:0]       lane_wdata,
    output logic [31:0]       load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half-word out of the returned word.
    always_comb begin
        case (byte_off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Strobes and replicated store data, and sign/zero-extended load data, per memop.
    always_comb begin
        wstrb      = 4'b0000;
        lane_wdata = wdata;
        load_data  = 32'h0;
        case (memop)
            MOP_SB: begin
                wstrb      = 4'b0001 << byte_off;
                lane_wdata = {4{wdata[7:0]}};
            end
            MOP_SH: begin
                wstrb      = byte_off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
            end
            MOP_SW:  wstrb     = 4'b1111;
            MOP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            MOP_LBU: load_data = {24'h0, byte_sel};
            MOP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            MOP_LHU: load_data = {16'h0, half_sel};
            MOP_LW:  load_data = rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage data bus sequencer and stall source; DMEM_ALIGN_CHECK_EN enables address-error detection
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [MMOP_W-1:0] memop,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              flush,
    input  logic              pipe_stall,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              adel_o,
    output logic              ades_o
);

    state_e            state_q, state_d;
    logic [MMOP_W-1:0] op_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              abort_q, abort_d;
    logic              latch;
    logic              capture;
    logic              misalign;
    logic              accept;
    logic [31:0]       load_data;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = misaligned(memop, addr[1:0]);
    assign adel_o   = (state_q == ST_IDLE) & req_valid & ~flush & is_load(memop) & misalign;
    assign ades_o   = (state_q == ST_IDLE) & req_valid & ~flush & is_store(memop) & misalign;
`else
    assign misalign = 1'b0;
    assign adel_o   = 1'b0;
    assign ades_o   = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) & req_valid & ~flush & ~misalign &
                    (is_load(memop) | is_store(memop));

    // Bus request fields come straight from the latched op so they stay stable until addr_ok.
    assign data_addr = addr_q;
    assign data_size = op_size(op_q);
    assign data_wr   = (state_q == ST_ADDR) & is_store(op_q);
    assign rdata_o   = rdata_q;

    dmem_lane u_lane (
        .memop      (op_q),
        .byte_off   (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (data_rdata),
        .wstrb      (data_wstrb),
        .lane_wdata (data_wdata),
        .load_data  (load_data)
    );

    // State and pending-flush registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
        end
    end

    // Capture the accepted op and, for loads, the extended read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= MOP_NOP;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            if (latch) begin
                op_q    <= memop;
                addr_q  <= align_addr(memop, addr);
                wdata_q <= wdata;
            end
            if (capture) begin
                rdata_q <= load_data;
            end
        end
    end

    // Next state, stall, request and result-valid; a flush only redirects an issued transfer to DISCARD.
    always_comb begin
        state_d       = state_q;
        abort_d       = abort_q;
        stall_o       = 1'b0;
        data_req      = 1'b0;
        rdata_valid_o = 1'b0;
        latch         = 1'b0;
        capture       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (accept) begin
                    latch   = 1'b1;
                    stall_o = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                stall_o  = 1'b1;
                data_req = 1'b1;
                if (flush) begin
                    abort_d = 1'b1;
                end
                if (data_addr_ok) begin
                    abort_d = 1'b0;
                    state_d = (abort_q | flush) ? ST_DISCARD : ST_DATA;
                end
            end
            ST_DATA: begin
                stall_o = 1'b1;
                if (flush) begin
                    state_d = data_data_ok ? ST_IDLE : ST_DISCARD;
                end else if (data_data_ok) begin
                    capture = is_load(op_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rdata_valid_o = is_load(op_q) & ~flush;
                if (flush | ~pipe_stall) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                stall_o = req_valid;
                if (data_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed vector table plus hand sequences for dmem_ctrl
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [MMOP_W-1:0] memop;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              flush;
    logic              pipe_stall;
    logic              stall_o;
    logic [31:0]       rdata_o;
    logic              rdata_valid_o;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [31:0]       data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic              adel_o;
    logic              ades_o;

    int tests = 0;
    int fails = 0;

    dmem_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .memop         (memop),
        .addr          (addr),
        .wdata         (wdata),
        .flush         (flush),
        .pipe_stall    (pipe_stall),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wstrb    (data_wstrb),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .adel_o        (adel_o),
        .ades_o        (ades_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MMOP_W-1:0] op;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [31:0]       rdata;
        int                aw;
        int                dw;
        int                exp_stalls;
        logic [31:0]       exp_addr;
        logic [3:0]        exp_wstrb;
        logic [31:0]       exp_wdata;
        logic [1:0]        exp_size;
        logic              exp_wr;
        logic [31:0]       exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},  32'(stall_o), 32'h0);
        chk({tag, "_req"},    32'(data_req), 32'h0);
        chk({tag, "_wr"},     32'(data_wr), 32'h0);
        chk({tag, "_rvalid"}, 32'(rdata_valid_o), 32'h0);
        chk({tag, "_adel"},   32'(adel_o), 32'h0);
        chk({tag, "_ades"},   32'(ades_o), 32'h0);
        chk({tag, "_addr"},   data_addr, 32'h0);
        chk({tag, "_wdata"},  data_wdata, 32'h0);
        chk({tag, "_wstrb"},  32'(data_wstrb), 32'h0);
        chk({tag, "_size"},   32'(data_size), 32'h0);
        chk({tag, "_rdata"},  rdata_o, 32'h0);
    endtask

    // Drives one op through the bus handshake with the vector's wait counts and checks it.
    task automatic run_vec(input int idx, input vec_t v);
        int    aw, dw, stalls, unstable;
        bit    in_data, done;
        string t;
        aw = v.aw; dw = v.dw; stalls = 0; unstable = 0; in_data = 0; done = 0;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        req_valid = 1'b1; memop = v.op; addr = v.addr; wdata = v.wdata; data_rdata = v.rdata;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            if (stall_o) stalls++;
            if (data_req) begin
                if (data_addr !== v.exp_addr) unstable++;
                if (aw > 0) begin
                    aw--;
                end else begin
                    chk({t, "_addr"},  data_addr, v.exp_addr);
                    chk({t, "_wstrb"}, 32'(data_wstrb), 32'(v.exp_wstrb));
                    chk({t, "_size"},  32'(data_size), 32'(v.exp_size));
                    chk({t, "_wr"},    32'(data_wr), 32'(v.exp_wr));
                    if (v.exp_wr) chk({t, "_wdata"}, data_wdata, v.exp_wdata);
                    data_addr_ok = 1'b1;
                    in_data = 1;
                end
            end else if (in_data) begin
                if (dw > 0) begin
                    dw--;
                end else begin
                    data_data_ok = 1'b1;
                    in_data = 0;
                end
            end else if (cyc > 0 && !stall_o) begin
                chk({t, "_rvalid"}, 32'(rdata_valid_o), 32'(!v.exp_wr));
                if (!v.exp_wr) chk({t, "_rdata"}, rdata_o, v.exp_rdata);
                done = 1;
                req_valid = 1'b0;
                memop = MOP_NOP;
            end
            @(negedge clk);
        end
        chk({t, "_done"}, 32'(done), 32'h1);
        chk({t, "_stalls"}, 32'(stalls), 32'(v.exp_stalls));
        chk({t, "_stable"}, 32'(unstable), 32'h0);
        req_valid = 1'b0; memop = MOP_NOP; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; memop = MOP_NOP; addr = 32'h0; wdata = 32'h0;
        flush = 1'b0; pipe_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = 32'h0;

        //            op       addr          wdata         rdata         aw dw st exp_addr      wstrb  exp_wdata     sz    wr    exp_rdata
        vecs.push_back('{MOP_LW,  32'h0000_1004, 32'h0,         32'hDEADBEEF, 0, 0, 3, 32'h0000_1004, 4'h0, 32'h0,         2'd2, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{MOP_LB,  32'h0000_2003, 32'h0,         32'h8000_0000, 0, 0, 3, 32'h0000_2003, 4'h0, 32'h0,        2'd0, 1'b0, 32'hFFFF_FF80});
        vecs.push_back('{MOP_LBU, 32'h0000_2003, 32'h0,         32'h8000_0000, 0, 0, 3, 32'h0000_2003, 4'h0, 32'h0,        2'd0, 1'b0, 32'h0000_0080});
        vecs.push_back('{MOP_LH,  32'h0000_2002, 32'h0,         32'h8001_0000, 0, 0, 3, 32'h0000_2002, 4'h0, 32'h0,        2'd1, 1'b0, 32'hFFFF_8001});
        vecs.push_back('{MOP_LHU, 32'h0000_3000, 32'h0,         32'h1234_F00D, 0, 0, 3, 32'h0000_3000, 4'h0, 32'h0,        2'd1, 1'b0, 32'h0000_F00D});
        vecs.push_back('{MOP_LB,  32'h0000_0001, 32'h0,         32'h0000_7F00, 0, 0, 3, 32'h0000_0001, 4'h0, 32'h0,        2'd0, 1'b0, 32'h0000_007F});
        vecs.push_back('{MOP_SB,  32'h0000_0101, 32'h0000_00AB, 32'h0,        0, 0, 3, 32'h0000_0101, 4'h2, 32'hABAB_ABAB, 2'd0, 1'b1, 32'h0});
        vecs.push_back('{MOP_SH,  32'h0000_0102, 32'h0000_1234, 32'h0,        0, 0, 3, 32'h0000_0102, 4'hC, 32'h1234_1234, 2'd1, 1'b1, 32'h0});
        vecs.push_back('{MOP_SW,  32'h0000_0200, 32'hCAFE_BABE, 32'h0,        0, 0, 3, 32'h0000_0200, 4'hF, 32'hCAFE_BABE, 2'd2, 1'b1, 32'h0});
        vecs.push_back('{MOP_LW,  32'h0000_1004, 32'h0,         32'h0BAD_F00D, 4, 0, 7, 32'h0000_1004, 4'h0, 32'h0,        2'd2, 1'b0, 32'h0BAD_F00D});
        vecs.push_back('{MOP_SW,  32'h0000_0300, 32'h1111_2222, 32'h0,        0, 2, 5, 32'h0000_0300, 4'hF, 32'h1111_2222, 2'd2, 1'b1, 32'h0});
`ifndef DMEM_ALIGN_CHECK_EN
        vecs.push_back('{MOP_LH,  32'h0000_2003, 32'h0,         32'h8001_0000, 0, 0, 3, 32'h0000_2002, 4'h0, 32'h0,        2'd1, 1'b0, 32'hFFFF_8001});
`endif

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Flush while in ADDR: old op drains through DISCARD, the next LW waits then issues.
        @(negedge clk);
        req_valid = 1'b1; memop = MOP_LW; addr = 32'h0000_0040;
        #1 chk("fa_accept_stall", 32'(stall_o), 32'h1);
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b0; memop = MOP_NOP;
        #1 chk("fa_req_in_addr", 32'(data_req), 32'h1);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b1; memop = MOP_LW; addr = 32'h0000_0080; data_addr_ok = 1'b1;
        #1 chk("fa_old_addr", data_addr, 32'h0000_0040);
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
        #1 chk("fa_discard_stall", 32'(stall_o), 32'h1);
        chk("fa_discard_noreq", 32'(data_req), 32'h0);
        chk("fa_discard_nvalid", 32'(rdata_valid_o), 32'h0);
        @(negedge clk);
        data_data_ok = 1'b0;
        #1 chk("fa_new_accept", 32'(stall_o), 32'h1);
        chk("fa_new_nvalid", 32'(rdata_valid_o), 32'h0);
        @(negedge clk);
        data_addr_ok = 1'b1;
        #1 chk("fa_new_req", 32'(data_req), 32'h1);
        chk("fa_new_addr", data_addr, 32'h0000_0080);
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h2222_2222;
        @(negedge clk);
        data_data_ok = 1'b0; pipe_stall = 1'b1;
        #1 chk("fa_done_valid", 32'(rdata_valid_o), 32'h1);
        chk("fa_done_rdata", rdata_o, 32'h2222_2222);
        chk("fa_done_stall", 32'(stall_o), 32'h0);

        // DONE held by pipe_stall never reissues; a flush there kills the result.
        @(negedge clk);
        #1 chk("dn_hold_valid", 32'(rdata_valid_o), 32'h1);
        chk("dn_hold_noreq", 32'(data_req), 32'h0);
        flush = 1'b1;
        #1 chk("dn_flush_valid", 32'(rdata_valid_o), 32'h0);
        @(negedge clk);
        flush = 1'b0; pipe_stall = 1'b0; req_valid = 1'b0; memop = MOP_NOP;
        #1 chk("dn_idle_stall", 32'(stall_o), 32'h0);
        chk("dn_idle_noreq", 32'(data_req), 32'h0);

        // Asynchronous reset while in DATA clears everything that same cycle.
        @(negedge clk);
        req_valid = 1'b1; memop = MOP_SW; addr = 32'h1234_5678; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0; req_valid = 1'b0; memop = MOP_NOP;
        #1 chk("rs_data_stall", 32'(stall_o), 32'h1);
        chk("rs_data_addr", data_addr, 32'h1234_5678);
        rst = 1'b1;
        #1 chk_all_zero("rs_mid");
        @(negedge clk);
        rst = 1'b0;

`ifdef DMEM_ALIGN_CHECK_EN
        // Misaligned accesses raise an address error and never reach the bus.
        @(negedge clk);
        req_valid = 1'b1; memop = MOP_SW; addr = 32'h0000_0102; wdata = 32'h0;
        #1 chk("al_ades", 32'(ades_o), 32'h1);
        chk("al_s_adel", 32'(adel_o), 32'h0);
        chk("al_s_stall", 32'(stall_o), 32'h0);
        @(negedge clk);
        req_valid = 1'b0; memop = MOP_NOP;
        #1 chk("al_s_noreq", 32'(data_req), 32'h0);
        chk("al_ades_clear", 32'(ades_o), 32'h0);
        @(negedge clk);
        req_valid = 1'b1; memop = MOP_LH; addr = 32'h0000_0101;
        #1 chk("al_adel", 32'(adel_o), 32'h1);
        chk("al_l_stall", 32'(stall_o), 32'h0);
        @(negedge clk);
        req_valid = 1'b0; memop = MOP_NOP;
        #1 chk("al_l_noreq", 32'(data_req), 32'h0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
